// File: rtl/serial_pattern_tx_if.sv
// Handshake bundle between a pattern source/controller and serial_pattern_tx.
// master drives the request side; slave is the transmitter.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) ();
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             repeat_en;
  logic             P1;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, data, len, repeat_en,
    input  P1, bit_valid, busy, done
  );

  modport slave (
    input  start, data, len, repeat_en,
    output P1, bit_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: latches a word and length on start and emits
// the selected bits MSB-first on P1, optionally repeating the word back-to-back.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_pattern_tx_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [LEN_W-1:0] WidthL = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rld_q, rld_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;

  // Out-of-range lengths fall back to the full word; left-align so bit len-1 is the MSB.
  always_comb begin
    eff_len = bus.len;
    if (bus.len == '0 || bus.len > WidthL) begin
      eff_len = WidthL;
    end
    shamt   = WidthL - eff_len;
    aligned = bus.data << shamt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rld_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StShift;
      StShift: if (cnt_q == '0 && !bus.repeat_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d = aligned;
          hold_d  = aligned;
          cnt_d   = eff_len - LEN_W'(1);
          rld_d   = eff_len - LEN_W'(1);
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - LEN_W'(1);
        end else if (bus.repeat_en) begin
          // Reload the held word so the next pass follows with no gap cycle.
          shift_d = hold_q;
          cnt_d   = rld_q;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.P1        = (state_q == StShift) && shift_q[WIDTH-1];
    bus.bit_valid = (state_q == StShift);
    bus.busy      = (state_q == StShift);
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx with hand-computed bit sequences.
module tb_serial_pattern_tx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_pattern_tx_if #(.WIDTH(8), .LEN_W(4)) bus ();

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.data      = '0;
    bus.len       = '0;
    bus.repeat_en = 1'b0;
    #15;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b, required 0000", i,
                 {bus.P1, bus.bit_valid, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    exp = 4'b1011;
    bus.data  = 8'b0000_1011;
    bus.len   = 4'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== {exp[3-i], 3'b110}) begin
        errors++;
        $display("FAIL basic_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid, bus.busy, bus.done}, {exp[3-i], 3'b110});
      end
      tick();
    end
    checks++;
    if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== 4'b0001) begin
      errors++;
      $display("FAIL basic_done: got %b, required 0001",
               {bus.P1, bus.bit_valid, bus.busy, bus.done});
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b, required 0", bus.done);
    end
  endtask

  // len=0 means full width; start stays high throughout and relaunches in the done cycle.
  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [3:0] exp2;
    exp  = 8'b1011_0110;
    exp2 = 4'b1100;
    bus.data  = 8'b1011_0110;
    bus.len   = 4'd0;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        bus.data = 8'h0C;
        bus.len  = 4'd4;
      end
      checks++;
      if ({bus.P1, bus.bit_valid, bus.busy} !== {exp[7-i], 2'b11}) begin
        errors++;
        $display("FAIL full_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid, bus.busy}, {exp[7-i], 2'b11});
      end
      tick();
    end
    checks++;
    if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== 4'b0001) begin
      errors++;
      $display("FAIL full_done: got %b, required 0001",
               {bus.P1, bus.bit_valid, bus.busy, bus.done});
    end
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== {exp2[3-i], 3'b110}) begin
        errors++;
        $display("FAIL b2b_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid, bus.busy, bus.done}, {exp2[3-i], 3'b110});
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: got %b, required 01", {bus.busy, bus.done});
    end
    tick();
  endtask

  task automatic test_repeat();
    logic [8:0] exp;
    exp = 9'b101_101_101;
    bus.data      = 8'b0000_0101;
    bus.len       = 4'd3;
    bus.repeat_en = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) bus.repeat_en = 1'b0;
      checks++;
      if ({bus.P1, bus.bit_valid, bus.done} !== {exp[8-i], 2'b10}) begin
        errors++;
        $display("FAIL repeat_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid, bus.done}, {exp[8-i], 2'b10});
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL repeat_done: got %b, required 01", {bus.busy, bus.done});
    end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL repeat_single_done: got %b, required 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    exp = 6'b110101;
    bus.data  = 8'b0011_0101;
    bus.len   = 4'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.P1 !== exp[5-i]) begin
        errors++;
        $display("FAIL abort_pre_bit %0d: got %b, required %b", i, bus.P1, exp[5-i]);
      end
      tick();
    end
    checks++;
    if (bus.P1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_bit3: got %b, required 1", bus.P1);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.P1, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_async: got %b, required 0000",
               {bus.P1, bus.bit_valid, bus.busy, bus.done});
    end
    @(posedge clk);
    #4;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_done %0d: got %b, required 00", i, {bus.busy, bus.done});
      end
    end
    exp = 6'b101101;
    bus.data  = 8'b0010_1101;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.P1, bus.bit_valid} !== {exp[5-i], 1'b1}) begin
        errors++;
        $display("FAIL restart_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid}, {exp[5-i], 1'b1});
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: got %b, required 1", bus.done);
    end
    tick();
  endtask

  task automatic test_len_edges();
    logic [7:0] exp;
    bus.data  = 8'h01;
    bus.len   = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.P1, bus.bit_valid, bus.done} !== 3'b110) begin
      errors++;
      $display("FAIL len1_bit: got %b, required 110", {bus.P1, bus.bit_valid, bus.done});
    end
    tick();
    checks++;
    if ({bus.P1, bus.bit_valid, bus.done} !== 3'b001) begin
      errors++;
      $display("FAIL len1_done: got %b, required 001", {bus.P1, bus.bit_valid, bus.done});
    end
    tick();
    exp = 8'hA5;
    bus.data  = 8'hA5;
    bus.len   = 4'd12;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.P1, bus.bit_valid} !== {exp[7-i], 1'b1}) begin
        errors++;
        $display("FAIL len12_bit %0d: got %b, required %b", i,
                 {bus.P1, bus.bit_valid}, {exp[7-i], 1'b1});
      end
      tick();
    end
    checks++;
    if ({bus.bit_valid, bus.done} !== 2'b01) begin
      errors++;
      $display("FAIL len12_done: got %b, required 01", {bus.bit_valid, bus.done});
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_repeat();
    test_reset_mid();
    test_len_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-pattern transmitter: the transmitting end of the single-bit serial line (`P1`) consumed by the Mealy sequence detector. It latches a parallel word and a bit count on a start strobe and emits the selected bits MSB-first, one bit per clock. It reports progress with `busy`, `bit_valid` and `done`, and can optionally repeat the word back-to-back. It replaces hand-written stimulus and drives the detector directly in integration benches and on the board.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `start`  in  1: request to begin transmission; sampled only in IDLE.
- `data`  in  WIDTH: pattern word; bits `[len-1:0]` are sent, `data[len-1]` first.
- `len`  in  LEN_W: number of bits to send; 0 or >WIDTH is treated as WIDTH.
- `repeat_en`  in  1: when high on the last-bit cycle, the latched word restarts immediately.
- `P1`  out  1: serial output bit; 0 whenever `bit_valid` is 0.
- `bit_valid`  out  1: high while `P1` carries a pattern bit.
- `busy`  out  1: high from the cycle after an accepted `start` until the last bit ends.
- `done`  out  1: one-cycle pulse in the cycle after the final bit (no repeat).

## Operation
- States:
  - IDLE: outputs low; waits for `start`.
  - SHIFT: one bit is presented per cycle.
- Transitions:
  - IDLE→SHIFT on `start`=1. Latch `data` into the shift register, left-aligned so that bit `len-1` is at the MSB. Latch the effective length `L` (1..WIDTH) and load the bit counter with `L-1`.
  - SHIFT, counter >0: shift left by one and decrement the counter.
  - SHIFT, counter =0 (last bit) with `repeat_en`=1: reload the original latched word (kept in a separate hold register) and `L-1`, and stay in SHIFT. No gap cycle.
  - SHIFT, counter =0 with `repeat_en`=0: go to IDLE and assert `done` for one cycle.
- Outputs:
  - `P1` is the MSB of the shift register, registered. It changes only on clock edges (Moore output; glitch-free toward the detector).
  - `start` while busy is ignored. `data` and `len` changes while busy have no effect.
  - `start` in the same cycle that `done` is high is accepted, so back-to-back words have exactly one idle cycle between them.
- Reset values: `P1`=0, `bit_valid`=0, `busy`=0, `done`=0, state=IDLE, counter=0, shift and hold registers=0.
- Reset asserted mid-transmission aborts immediately (asynchronously): `P1` drops to 0 and no `done` pulse is issued. After release the block is in IDLE.

## Timing
- Latency: `start` sampled high at edge k → first bit on `P1` with `bit_valid`=1 and `busy`=1 from edge k to edge k+1.
- Bit i (0-based) of the transmission is valid between edges k+i and k+i+1, for i = 0..L-1.
- `done`=1 between edges k+L and k+L+1. In that cycle `busy`=0 and `bit_valid`=0.
- Repeat mode: bit 0 of the next pass follows bit L-1 on the next edge. `done` is not asserted until the final non-repeated pass ends.
- L=1: a single bit, then `done` on the next cycle.
- Throughput: L bits per L+1 cycles without repeat; L bits per L cycles with repeat.

## Test plan
- Reset hold 15 ns then release; `start`=0 → `P1`=`bit_valid`=`busy`=`done`=0 indefinitely.
- `data`=8'b0000_1011, `len`=4, `start` pulse → `P1`=1,0,1,1 on cycles k..k+3 with `bit_valid`=1, `done`=1 at k+4. The connected Mealy detector `z` pulses on the final 1.
- `data`=8'b1011_0110, `len`=0 (treated as 8) → `P1`=1,0,1,1,0,1,1,0, then `done`. A `start` held high during the transfer is ignored. A `start` high during the `done` cycle begins the next word at k+9.
- `data`=3'b101, `len`=3, `repeat_en`=1 for two passes, then 0 → `P1`=1,0,1,1,0,1,1,0,1 with no gap. A single `done` follows the third pass.
- `len`=6, `reset` asserted asynchronously mid-bit 3 → `P1`, `busy` and `bit_valid` go to 0 before the next edge. No `done`. A fresh `start` after release transmits correctly from bit 0.
- `len`=1, `data[0]`=1 → one-cycle `P1`=1, then `done`. `len`=12 with WIDTH=8 → 8 bits sent.
